ipsxe_floating_point_frac_widen_v1_0: RTL and testbench

- Widening float-to-float converter for the fl2fl path (default single -> double), the counterpart of the narrowing fraction rounder.
- Exact conversion, no rounding: unpack, classify, normalize subnormals, rebias the exponent, left-align the fraction.
- 3-stage pipeline with AXI4-Stream-style valid/ready on both sides. Sits between the fl2fl input register and the result packer.

---
 rtl/ipsxe_floating_point_fl2fl_pkg.sv | 27 ++
 rtl/ipsxe_floating_point_lzc_v1_0.sv | 21 ++
 rtl/ipsxe_floating_point_frac_widen_v1_0.sv | 186 ++++++++++++++++++
 tb/tb_ipsxe_floating_point_frac_widen_v1_0.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_fl2fl_pkg.sv
// Shared definitions for the fl2fl float-to-float conversion path.
// Holds operand class codes, exponent bias helpers and the quiet-bit index.
package ipsxe_floating_point_fl2fl_pkg;

   localparam logic [2:0] CLS_ZERO = 3'd0;
   localparam logic [2:0] CLS_SUB  = 3'd1;
   localparam logic [2:0] CLS_NORM = 3'd2;
   localparam logic [2:0] CLS_INF  = 3'd3;
   localparam logic [2:0] CLS_NAN  = 3'd4;

   // Input format exponent bias for an exponent of width exp_w.
   function automatic int BI(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Output format exponent bias for an exponent of width exp_w.
   function automatic int BO(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Index of the quiet bit inside the stored fraction field, where
   // frac_w counts the hidden bit.
   function automatic int QBIT(input int frac_w);
      return frac_w - 2;
   endfunction

endpackage

// File: rtl/ipsxe_floating_point_lzc_v1_0.sv
// Parameterized leading-zero counter.
// Ports: data_i (WIDTH bits) in, cnt_o = number of leading zeros (WIDTH if all zero).
module ipsxe_floating_point_lzc_v1_0
   import ipsxe_floating_point_fl2fl_pkg::*;
#(
   parameter int WIDTH = 23,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [CNT_W-1:0] cnt_o
);

   // Scan upward so the most significant set bit has the last word.
   always_comb begin
      cnt_o = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/ipsxe_floating_point_frac_widen_v1_0.sv
// Exact widening float-to-float converter (default single -> double), 3-stage
// valid/ready pipeline: S1 classify, S2 normalize subnormals, S3 rebias and pack.
// Ports: i_aclk, i_areset_n (sync, active low), i_aclken (clock enable),
//   a-side stream in {sign,exp,frac}, result stream out, tuser = input was sNaN.
// Build option: define IPSXE_FLT_DENORM_EN to normalize subnormal inputs;
//   otherwise subnormals are flushed to signed zero.
module ipsxe_floating_point_frac_widen_v1_0
   import ipsxe_floating_point_fl2fl_pkg::*;
#(
   parameter int FLOAT_IN_EXP   = 8,
   parameter int FLOAT_IN_FRAC  = 24,
   parameter int FLOAT_OUT_EXP  = 11,
   parameter int FLOAT_OUT_FRAC = 53
) (
   input  logic                                   i_aclk,
   input  logic                                   i_areset_n,
   input  logic                                   i_aclken,
   input  logic                                   i_axi4s_a_tvalid,
   output logic                                   o_axi4s_a_tready,
   input  logic [FLOAT_IN_EXP+FLOAT_IN_FRAC-1:0]  i_axi4s_a_tdata,
   output logic                                   o_axi4s_result_tvalid,
   input  logic                                   i_axi4s_result_tready,
   output logic [FLOAT_OUT_EXP+FLOAT_OUT_FRAC-1:0] o_axi4s_result_tdata,
   output logic                                   o_axi4s_result_tuser
);

   localparam int IEW    = FLOAT_IN_EXP;
   localparam int IFW    = FLOAT_IN_FRAC - 1;
   localparam int OEW    = FLOAT_OUT_EXP;
   localparam int OFW    = FLOAT_OUT_FRAC - 1;
   localparam int REBIAS = BO(OEW) - BI(IEW);
   localparam int QI_IN  = QBIT(FLOAT_IN_FRAC);
   localparam int QI_OUT = QBIT(FLOAT_OUT_FRAC);

   // Handshake: each stage loads when enabled and its successor has room.
   logic res_en, s2_en, s1_en;
   logic s1_v_q, s2_v_q, res_v_q;

   assign res_en = i_aclken & (~res_v_q | i_axi4s_result_tready);
   assign s2_en  = i_aclken & (~s2_v_q | res_en);
   assign s1_en  = i_aclken & (~s1_v_q | s2_en);
   assign o_axi4s_a_tready = s1_en;

   // S1: unpack and classify
   logic           s1_sign_d, s1_sign_q;
   logic [IEW-1:0] s1_exp_d, s1_exp_q;
   logic [IFW-1:0] s1_frac_d, s1_frac_q;
   logic [2:0]     s1_cls_d, s1_cls_q;
   logic           exp_zero, exp_ones, frac_zero;

   assign s1_sign_d = i_axi4s_a_tdata[IEW+IFW];
   assign s1_exp_d  = i_axi4s_a_tdata[IEW+IFW-1:IFW];
   assign s1_frac_d = i_axi4s_a_tdata[IFW-1:0];
   assign exp_zero  = ~|s1_exp_d;
   assign exp_ones  = &s1_exp_d;
   assign frac_zero = ~|s1_frac_d;

   always_comb begin
      s1_cls_d = CLS_NORM;
      unique case (1'b1)
         exp_zero &  frac_zero: s1_cls_d = CLS_ZERO;
         exp_zero & ~frac_zero: s1_cls_d = CLS_SUB;
         exp_ones &  frac_zero: s1_cls_d = CLS_INF;
         exp_ones & ~frac_zero: s1_cls_d = CLS_NAN;
         default:               s1_cls_d = CLS_NORM;
      endcase
   end

   always_ff @(posedge i_aclk) begin
      if (!i_areset_n) begin
         s1_v_q    <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_exp_q  <= '0;
         s1_frac_q <= '0;
         s1_cls_q  <= CLS_ZERO;
      end else if (s1_en) begin
         s1_v_q    <= i_axi4s_a_tvalid;
         s1_sign_q <= s1_sign_d;
         s1_exp_q  <= s1_exp_d;
         s1_frac_q <= s1_frac_d;
         s1_cls_q  <= s1_cls_d;
      end
   end

   // S2: normalize subnormals
   logic [IFW-1:0] s2_frac_d, s2_frac_q;
   logic           s2_sign_q;
   logic [IEW-1:0] s2_exp_q;
   logic [2:0]     s2_cls_q;

`ifdef IPSXE_FLT_DENORM_EN
   localparam int LZW = $clog2(IFW + 1);
   logic [LZW-1:0] lz, s2_lz_q;

   ipsxe_floating_point_lzc_v1_0 #(
      .WIDTH (IFW),
      .CNT_W (LZW)
   ) u_lzc (
      .data_i (s1_frac_q),
      .cnt_o  (lz)
   );

   // Shift by lz+1 so the leading one becomes the hidden bit and drops out.
   assign s2_frac_d = (s1_cls_q == CLS_SUB) ? ((s1_frac_q << lz) << 1)
                                            : s1_frac_q;
`else
   assign s2_frac_d = s1_frac_q;
`endif

   always_ff @(posedge i_aclk) begin
      if (!i_areset_n) begin
         s2_v_q    <= 1'b0;
         s2_sign_q <= 1'b0;
         s2_exp_q  <= '0;
         s2_frac_q <= '0;
         s2_cls_q  <= CLS_ZERO;
`ifdef IPSXE_FLT_DENORM_EN
         s2_lz_q   <= '0;
`endif
      end else if (s2_en) begin
         s2_v_q    <= s1_v_q;
         s2_sign_q <= s1_sign_q;
         s2_exp_q  <= s1_exp_q;
         s2_frac_q <= s2_frac_d;
         s2_cls_q  <= s1_cls_q;
`ifdef IPSXE_FLT_DENORM_EN
         s2_lz_q   <= lz;
`endif
      end
   end

   // S3: rebias exponent, left-align fraction, pack
   logic [OEW:0]   exp_w;
   logic [OFW-1:0] frac_o;
   logic           user_d;
   logic           unused_exp_msb;

   assign unused_exp_msb = exp_w[OEW];

   always_comb begin
      exp_w  = '0;
      frac_o = OFW'(s2_frac_q) << (OFW - IFW);
      user_d = 1'b0;
      case (s2_cls_q)
         CLS_NORM: exp_w = (OEW+1)'(s2_exp_q) + (OEW+1)'(REBIAS);
         CLS_SUB: begin
`ifdef IPSXE_FLT_DENORM_EN
            exp_w = (OEW+1)'(REBIAS) - (OEW+1)'(s2_lz_q);
`else
            exp_w  = '0;
            frac_o = '0;
`endif
         end
         CLS_INF: begin
            exp_w  = {1'b0, {OEW{1'b1}}};
            frac_o = '0;
         end
         CLS_NAN: begin
            exp_w          = {1'b0, {OEW{1'b1}}};
            frac_o[QI_OUT] = 1'b1;
            user_d         = ~s2_frac_q[QI_IN];
         end
         default: begin
            exp_w  = '0;
            frac_o = '0;
         end
      endcase
   end

   always_ff @(posedge i_aclk) begin
      if (!i_areset_n) begin
         res_v_q              <= 1'b0;
         o_axi4s_result_tdata <= '0;
         o_axi4s_result_tuser <= 1'b0;
      end else if (res_en) begin
         res_v_q <= s2_v_q;
         if (s2_v_q) begin
            o_axi4s_result_tdata <= {s2_sign_q, exp_w[OEW-1:0], frac_o};
            o_axi4s_result_tuser <= user_d;
         end
      end
   end

   assign o_axi4s_result_tvalid = res_v_q;

endmodule

// File: tb/tb_ipsxe_floating_point_frac_widen_v1_0.sv
// Self-checking bench for the single -> double widening converter.
// Random and directed stimulus checked against a real-arithmetic reference.
module tb_ipsxe_floating_point_frac_widen_v1_0;

`ifdef IPSXE_FLT_DENORM_EN
   localparam bit DENORM = 1'b1;
`else
   localparam bit DENORM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        aclken;
   logic        a_tvalid;
   logic        a_tready;
   logic [31:0] a_tdata;
   logic        r_tvalid;
   logic        r_tready;
   logic [63:0] r_tdata;
   logic        r_tuser;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ipsxe_floating_point_frac_widen_v1_0 dut (
      .i_aclk                (clk),
      .i_areset_n            (rst_n),
      .i_aclken              (aclken),
      .i_axi4s_a_tvalid      (a_tvalid),
      .o_axi4s_a_tready      (a_tready),
      .i_axi4s_a_tdata       (a_tdata),
      .o_axi4s_result_tvalid (r_tvalid),
      .i_axi4s_result_tready (r_tready),
      .o_axi4s_result_tdata  (r_tdata),
      .o_axi4s_result_tuser  (r_tuser)
   );

   // Reference: value of the float computed in real arithmetic, then taken
   // as a double. Returns {tuser, data}.
   function automatic logic [64:0] ref_widen(input logic [31:0] x);
      logic s;
      int   e, f;
      real  m, v;
      s = x[31];
      e = int'(x[30:23]);
      f = int'(x[22:0]);
      if (e == 255) begin
         if (f == 0) return {1'b0, s, 11'h7FF, 52'h0};
         return {~x[22], s, 11'h7FF, 1'b1, x[21:0], 29'h0};
      end
      if (e == 0 && (f == 0 || !DENORM)) return {1'b0, s, 63'h0};
      m = (e == 0) ? real'(f) : real'(f + (1 << 23));
      v = m * (2.0 ** real'((e == 0) ? -149 : e - 150));
      if (s) v = -v;
      return {1'b0, $realtobits(v)};
   endfunction

   function automatic logic [31:0] rand_float();
      logic s;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
         0: return {s, 8'h00, 23'h0};
         1: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
         2: return {s, 8'hFF, 23'h0};
         3: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset;
      checks++;
      if (r_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_tvalid got %b exp 0", r_tvalid);
      end
      checks++;
      if (r_tdata !== 64'h0 || r_tuser !== 1'b0) begin
         errors++;
         $display("FAIL reset_data got %h/%b exp 0/0", r_tdata, r_tuser);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (a_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_tready got %b exp 1", a_tready);
      end
   endtask

   task automatic test_directed;
      logic [31:0] vin[9];
      logic [63:0] vexp[9];
      logic        uexp[9];
      int          lat;
      vin[0] = 32'h3F800000; vexp[0] = 64'h3FF0000000000000; uexp[0] = 0;
      vin[1] = 32'h00000001;
      vexp[1] = DENORM ? 64'h36A0000000000000 : 64'h0; uexp[1] = 0;
      vin[2] = 32'h007FFFFF;
      vexp[2] = DENORM ? 64'h380FFFFFC0000000 : 64'h0; uexp[2] = 0;
      vin[3] = 32'h00800000; vexp[3] = 64'h3810000000000000; uexp[3] = 0;
      vin[4] = 32'h80000000; vexp[4] = 64'h8000000000000000; uexp[4] = 0;
      vin[5] = 32'h7F800000; vexp[5] = 64'h7FF0000000000000; uexp[5] = 0;
      vin[6] = 32'h7F800001; vexp[6] = 64'h7FF8000020000000; uexp[6] = 1;
      vin[7] = 32'h7FC00000; vexp[7] = 64'h7FF8000000000000; uexp[7] = 0;
      vin[8] = 32'h80000001;
      vexp[8] = DENORM ? 64'hB6A0000000000000 : 64'h8000000000000000;
      uexp[8] = 0;
      r_tready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         a_tvalid = 1'b1;
         a_tdata  = vin[i];
         @(posedge clk); #1;
         a_tvalid = 1'b0;
         lat = 1;
         while (!r_tvalid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
         end
         checks++;
         if (lat !== 3) begin
            errors++;
            $display("FAIL latency_%h got %0d exp 3", vin[i], lat);
         end
         checks++;
         if (r_tdata !== vexp[i] || r_tuser !== uexp[i]) begin
            errors++;
            $display("FAIL dir_%h got %h/%b exp %h/%b",
                     vin[i], r_tdata, r_tuser, vexp[i], uexp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] vals[16];
      logic [64:0] expq[$];
      logic [64:0] e;
      logic [63:0] pd;
      logic        pu, pv, exp_rdy;
      int          acc, got, infl;
      acc = 0; got = 0; infl = 0; pv = 0; pd = '0; pu = 0;
      for (int i = 0; i < 16; i++) vals[i] = rand_float();
      for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
         r_tready = !(cyc >= 6 && cyc < 11);
         a_tvalid = (acc < 16);
         a_tdata  = vals[(acc < 16) ? acc : 0];
         #1;
         exp_rdy = !(infl == 3 && !r_tready);
         checks++;
         if (a_tready !== exp_rdy) begin
            errors++;
            $display("FAIL b2b_tready cyc %0d got %b exp %b", cyc, a_tready, exp_rdy);
         end
         if (pv) begin
            checks++;
            if (r_tvalid !== 1'b1 || r_tdata !== pd || r_tuser !== pu) begin
               errors++;
               $display("FAIL b2b_hold cyc %0d got %b %h exp 1 %h", cyc, r_tvalid, r_tdata, pd);
            end
         end
         if (r_tvalid && r_tready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra got %h exp none", r_tdata);
            end else begin
               e = expq.pop_front();
               if ({r_tuser, r_tdata} !== e) begin
                  errors++;
                  $display("FAIL b2b_data %0d got %b/%h exp %b/%h",
                           got, r_tuser, r_tdata, e[64], e[63:0]);
               end
            end
            got++;
            infl--;
         end
         if (a_tvalid && a_tready) begin
            expq.push_back(ref_widen(vals[acc]));
            acc++;
            infl++;
         end
         pv = r_tvalid && !r_tready;
         pd = r_tdata;
         pu = r_tuser;
         @(posedge clk); #1;
      end
      a_tvalid = 1'b0;
      checks++;
      if (got !== 16) begin
         errors++;
         $display("FAIL b2b_count got %0d exp 16", got);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (r_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_dup got tvalid %b exp 0", r_tvalid);
      end
   endtask

   task automatic test_aclken;
      logic [31:0] vals[4];
      logic [64:0] expq[$];
      logic [64:0] e;
      logic [63:0] sd;
      logic        su, sv;
      int          acc, got;
      acc = 0; got = 0; sd = '0; su = 0; sv = 0;
      for (int i = 0; i < 4; i++) vals[i] = rand_float();
      r_tready = 1'b1;
      for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
         aclken   = !(cyc >= 3 && cyc < 7);
         a_tvalid = (acc < 4);
         a_tdata  = vals[(acc < 4) ? acc : 0];
         #1;
         if (cyc == 3) begin
            sv = r_tvalid; sd = r_tdata; su = r_tuser;
         end
         if (cyc >= 4 && cyc <= 7) begin
            checks++;
            if (r_tvalid !== sv || r_tdata !== sd || r_tuser !== su) begin
               errors++;
               $display("FAIL aclken_hold cyc %0d got %b %h exp %b %h", cyc, r_tvalid, r_tdata, sv, sd);
            end
         end
         if (!aclken) begin
            checks++;
            if (a_tready !== 1'b0) begin
               errors++;
               $display("FAIL aclken_tready got %b exp 0", a_tready);
            end
         end
         if (r_tvalid && r_tready && aclken) begin
            checks++;
            e = (expq.size() != 0) ? expq.pop_front() : 65'h0;
            if ({r_tuser, r_tdata} !== e) begin
               errors++;
               $display("FAIL aclken_data %0d got %h exp %h", got, r_tdata, e[63:0]);
            end
            got++;
         end
         if (a_tvalid && a_tready) begin
            expq.push_back(ref_widen(vals[acc]));
            acc++;
         end
         @(posedge clk); #1;
      end
      aclken   = 1'b1;
      a_tvalid = 1'b0;
      checks++;
      if (!sv || got !== 4) begin
         errors++;
         $display("FAIL aclken_count got %0d/%b exp 4/1", got, sv);
      end
   endtask

   task automatic test_reset_inflight;
      int lat;
      r_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_tvalid = 1'b1;
         a_tdata  = rand_float();
         @(posedge clk); #1;
      end
      a_tvalid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (r_tvalid !== 1'b0 || r_tdata !== 64'h0 || r_tuser !== 1'b0) begin
         errors++;
         $display("FAIL rst_flight got %b %h exp 0 0", r_tvalid, r_tdata);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (r_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale cyc %0d got %b exp 0", i, r_tvalid);
         end
      end
      a_tvalid = 1'b1;
      a_tdata  = 32'hC0400000;
      @(posedge clk); #1;
      a_tvalid = 1'b0;
      lat = 1;
      while (!r_tvalid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (r_tvalid !== 1'b1 || r_tdata !== 64'hC008000000000000) begin
         errors++;
         $display("FAIL rst_after got %b %h exp 1 c008000000000000", r_tvalid, r_tdata);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      aclken   = 1'b1;
      a_tvalid = 1'b0;
      a_tdata  = '0;
      r_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(posedge clk); #1;
      test_directed();
      test_back_to_back();
      test_aclken();
      test_reset_inflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
